// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Imported by the receive controller, its edge/bit counter and the output interface.
package uart_rx_pkg;

    localparam int DATA_W     = 8;
    localparam int PRESCALE_W = 6;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Value the parity bit must carry for the given byte: even -> XOR, odd -> XNOR.
    function automatic logic expected_parity(input logic [DATA_W-1:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Parallel result bus from the UART receive controller to the RX-side CDC/FIFO logic.
// The controller drives it through the master modport; consumers use the slave modport.
interface uart_rx_ctrl_if #(
    parameter int DATA_W = uart_rx_pkg::DATA_W
);

    logic [DATA_W-1:0] P_DATA;
    logic              data_valid;
    logic              par_err;
    logic              stp_err;

    modport master (
        output P_DATA,
        output data_valid,
        output par_err,
        output stp_err
    );

    modport slave (
        input P_DATA,
        input data_valid,
        input par_err,
        input stp_err
    );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample edge counter (0..P-1) and per-bit counter for the UART receiver.
// The bit count advances on every edge-counter wrap; clear forces both counters to zero.
module uart_rx_edge_bit_counter #(
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_enable,
    input  logic [PRESCALE_W-1:0] i_pre_scale,
    input  logic                  i_clear,
    output logic [PRESCALE_W-1:0] o_edge_cnt,
    output logic [BIT_CNT_W-1:0]  o_bit_cnt,
    output logic                  o_last_edge
);

    import uart_rx_pkg::*;

    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic                  w_last_edge;

    assign w_last_edge = i_enable && (r_edge_cnt == (i_pre_scale - PRESCALE_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_clear) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (i_enable) begin
            if (w_last_edge) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= r_bit_cnt + BIT_CNT_W'(1);
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            end
        end
    end

    assign o_edge_cnt  = r_edge_cnt;
    assign o_bit_cnt   = r_bit_cnt;
    assign o_last_edge = w_last_edge;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frames start/data/parity/stop using the majority-voted sample,
// deserializes LSB-first and reports each frame as a one-cycle valid or error pulse.
module uart_rx_ctrl #(
    parameter int DATA_W     = uart_rx_pkg::DATA_W,
    parameter int PRESCALE_W = uart_rx_pkg::PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] pre_scale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  data_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    uart_rx_ctrl_if.master        rx_out
);

    import uart_rx_pkg::*;

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    rx_state_t         r_state;
    rx_state_t         w_next_state;
    logic              w_clear;
    logic              w_last_edge;
    logic [3:0]        w_bit_cnt;
    logic [DATA_W-1:0] r_p_data;
    logic              r_perr;
    logic              r_data_valid;
    logic              r_par_err;
    logic              r_stp_err;
    logic              w_serr;
    logic              w_perr_final;

    uart_rx_edge_bit_counter #(
        .PRESCALE_W (PRESCALE_W),
        .BIT_CNT_W  (4)
    ) u_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (data_samp_en),
        .i_pre_scale (pre_scale),
        .i_clear     (w_clear),
        .o_edge_cnt  (edge_cnt),
        .o_bit_cnt   (w_bit_cnt),
        .o_last_edge (w_last_edge)
    );

    assign data_samp_en = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Every state change restarts the counters so each new bit begins at edge 0 / bit 0.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_clear = 1'b1;
                if (!RX_IN) begin
                    w_next_state = START;
                end
            end
            START: begin
                if (w_last_edge) begin
                    w_clear      = 1'b1;
                    w_next_state = sampled_bit ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_last_edge && (w_bit_cnt == LAST_BIT)) begin
                    w_clear      = 1'b1;
                    w_next_state = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_last_edge) begin
                    w_clear      = 1'b1;
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_last_edge) begin
                    w_clear      = 1'b1;
                    w_next_state = RX_IN ? IDLE : START;
                end
            end
            default: begin
                w_clear      = 1'b1;
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_serr       = ~sampled_bit;
    assign w_perr_final = r_perr & PAR_EN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_data     <= '0;
            r_perr       <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;

            if ((w_next_state == START) && (r_state != START)) begin
                r_perr <= 1'b0;
            end

            if (w_last_edge) begin
                unique case (r_state)
                    DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (w_bit_cnt == 4'(i)) begin
                                r_p_data[i] <= sampled_bit;
                            end
                        end
                    end
                    PARITY: begin
                        r_perr <= (sampled_bit != expected_parity(r_p_data, PAR_TYP));
                    end
                    STOP: begin
                        r_stp_err    <= w_serr;
                        r_par_err    <= w_perr_final;
                        r_data_valid <= ~w_serr & ~w_perr_final;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_out.P_DATA     = r_p_data;
    assign rx_out.data_valid = r_data_valid;
    assign rx_out.par_err    = r_par_err;
    assign rx_out.stp_err    = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl with a behavioural 3-sample majority data_sampling model.
// Frames come from a vector table plus hand-written corner sequences; a scoreboard checks each pulse.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    import uart_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] pre_scale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       sampled_bit;
    logic       data_samp_en;
    logic [5:0] edge_cnt;

    uart_rx_ctrl_if rxBus ();

    uart_rx_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RX_IN        (RX_IN),
        .pre_scale    (pre_scale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .sampled_bit  (sampled_bit),
        .data_samp_en (data_samp_en),
        .edge_cnt     (edge_cnt),
        .rx_out       (rxBus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Majority of three samples around mid-bit, result valid from edge_cnt P/2+1 onward
    logic s0, s1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0          <= 1'b1;
            s1          <= 1'b1;
            sampled_bit <= 1'b1;
        end else if (data_samp_en) begin
            if (edge_cnt == (pre_scale >> 1) - 6'd1)
                s0 <= RX_IN;
            else if (edge_cnt == (pre_scale >> 1))
                s1 <= RX_IN;
            else if (edge_cnt == (pre_scale >> 1) + 6'd1)
                sampled_bit <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
        end
    end

    typedef struct {
        int         presc;
        bit         parEn;
        bit         parTyp;
        logic [7:0] data;
        bit         parBit;
        bit         stopBit;
        bit         expValid;
        bit         expPerr;
        bit         expSerr;
    } vec_t;

    typedef struct {
        int         tag;
        logic [7:0] data;
        bit         valid;
        bit         perr;
        bit         serr;
        int         due;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbQ[$];
    int   validCycles[$];
    int   nChecks = 0;
    int   nErrors = 0;
    sb_t  monE;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one full frame starting at a negedge; each bit is held for presc clocks.
    task automatic applyStimulus(input int presc, input bit parEn, input bit parTyp,
                                 input logic [7:0] data, input bit parBit, input bit stopBit,
                                 input bit expValid, input bit expPerr, input bit expSerr,
                                 input bit push, input int tag);
        sb_t e;
        pre_scale = 6'(presc);
        PAR_EN    = parEn;
        PAR_TYP   = parTyp;
        RX_IN     = 1'b0;
        if (push) begin
            e.tag   = tag;
            e.data  = data;
            e.valid = expValid;
            e.perr  = expPerr;
            e.serr  = expSerr;
            e.due   = cyc + 1 + (parEn ? 11 : 10) * presc;
            sbQ.push_back(e);
        end
        repeat (presc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_IN = data[i];
            repeat (presc) @(negedge clk);
        end
        if (parEn) begin
            RX_IN = parBit;
            repeat (presc) @(negedge clk);
        end
        RX_IN = stopBit;
        repeat (presc) @(negedge clk);
    endtask

    task automatic idleLine(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && (rxBus.data_valid || rxBus.par_err || rxBus.stp_err)) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL unexpected_pulse: got valid=%0b perr=%0b serr=%0b, expected no pulse",
                         rxBus.data_valid, rxBus.par_err, rxBus.stp_err);
            end else begin
                monE = sbQ.pop_front();
                checkOutput($sformatf("f%0d_valid", monE.tag), rxBus.data_valid, monE.valid);
                checkOutput($sformatf("f%0d_par_err", monE.tag), rxBus.par_err, monE.perr);
                checkOutput($sformatf("f%0d_stp_err", monE.tag), rxBus.stp_err, monE.serr);
                checkOutput($sformatf("f%0d_latency_cycle", monE.tag), cyc, monE.due);
                checkOutput($sformatf("f%0d_p_data", monE.tag), rxBus.P_DATA, monE.data);
            end
            if (rxBus.data_valid) validCycles.push_back(cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_data_valid", rxBus.data_valid, 0);
        checkOutput("reset_par_err", rxBus.par_err, 0);
        checkOutput("reset_stp_err", rxBus.stp_err, 0);
        checkOutput("reset_p_data", rxBus.P_DATA, 0);
        checkOutput("reset_samp_en", data_samp_en, 0);
        checkOutput("reset_edge_cnt", edge_cnt, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        //                presc        pe    pt    data   pbit  stop  valid perr  serr
        vecs.push_back(vec_t'{PRESCALE_8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{PRESCALE_16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{PRESCALE_16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{PRESCALE_16, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{PRESCALE_16, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{PRESCALE_8,  1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{PRESCALE_32, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{PRESCALE_8,  1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{PRESCALE_32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{PRESCALE_8,  1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});

        for (int v = 0; v < vecs.size(); v++) begin
            applyStimulus(vecs[v].presc, vecs[v].parEn, vecs[v].parTyp, vecs[v].data,
                          vecs[v].parBit, vecs[v].stopBit, vecs[v].expValid,
                          vecs[v].expPerr, vecs[v].expSerr, 1'b1, v);
            idleLine(2 * vecs[v].presc);
        end

        // Glitch: start bit only two clocks wide
        pre_scale = 6'(PRESCALE_8);
        PAR_EN    = 1'b0;
        RX_IN     = 1'b0;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("glitch_edge_cnt_last", edge_cnt, 7);
        checkOutput("glitch_samp_en_busy", data_samp_en, 1);
        @(negedge clk);
        checkOutput("glitch_samp_en_idle", data_samp_en, 0);
        checkOutput("glitch_edge_cnt_idle", edge_cnt, 0);
        idleLine(16);

        // Stop error with the line still low: FSM must restart in START
        applyStimulus(PRESCALE_8, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 100);
        repeat (2) @(negedge clk);
        checkOutput("stoperr_restart_samp_en", data_samp_en, 1);
        checkOutput("stoperr_restart_edge_cnt", edge_cnt, 1);
        idleLine(24);
        checkOutput("stoperr_glitch_back_idle", data_samp_en, 0);

        // Back-to-back frames at P=32 with no idle gap
        validCycles.delete();
        applyStimulus(PRESCALE_32, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 101);
        applyStimulus(PRESCALE_32, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 102);
        idleLine(64);
        checkOutput("b2b_pulse_count", validCycles.size(), 2);
        if (validCycles.size() == 2)
            checkOutput("b2b_spacing", validCycles[1] - validCycles[0], 320);

        // Reset in the middle of data bit 3, then a clean frame
        pre_scale = 6'(PRESCALE_8);
        PAR_EN    = 1'b0;
        RX_IN     = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RX_IN = (i == 0) ? 1'b1 : 1'b0;
            repeat ((i == 3) ? 4 : 8) @(negedge clk);
        end
        checkOutput("midreset_busy_before", data_samp_en, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_p_data", rxBus.P_DATA, 0);
        checkOutput("midreset_valid", rxBus.data_valid, 0);
        checkOutput("midreset_par_err", rxBus.par_err, 0);
        checkOutput("midreset_stp_err", rxBus.stp_err, 0);
        checkOutput("midreset_samp_en", data_samp_en, 0);
        checkOutput("midreset_edge_cnt", edge_cnt, 0);
        RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idleLine(4);
        applyStimulus(PRESCALE_8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 103);
        idleLine(16);

        for (int i = 0; i < 2000 && sbQ.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", sbQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- UART receiver control stage.
- Drives the oversampling edge counter and the sample-enable into the majority-vote data_sampling stage, and consumes its sampled_bit.
- Frames start/data/parity/stop bits, deserializes 8 data bits LSB-first, checks parity and stop, and emits parallel data with a one-cycle valid pulse.
- Sits between the RX pin synchronizer and the RX-side clock-domain/FIFO logic.

Parameters:
- DATA_W, 8, data bits per frame.
- PRESCALE_W, 6, width of pre_scale and edge_cnt.

Ports:
- clk  in  1  receiver oversampling clock.
- rst_n  in  1  asynchronous active-low reset.
- RX_IN  in  1  synchronized serial line; idle high.
- pre_scale  in  6  oversampling ratio; legal values 8, 16, 32; static while a frame is in progress.
- PAR_EN  in  1  1 = parity bit present.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- sampled_bit  in  1  majority-voted bit from data_sampling.
- data_samp_en  out  1  enables data_sampling.
- edge_cnt  out  6  oversample edge index within the current bit.
- P_DATA  out  8  received byte.
- data_valid  out  1  one-cycle pulse: frame good.
- par_err  out  1  one-cycle pulse: parity mismatch.
- stp_err  out  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset values: all outputs 0; state IDLE; bit_cnt 0.
- P = pre_scale. The edge E0 is the first clock edge in IDLE that sees RX_IN == 0.

IDLE:
- data_samp_en = 0; edge_cnt held at 0.
- On RX_IN == 0, go to START with edge_cnt <= 0.

Counting in non-IDLE states:
- data_samp_en = 1.
- edge_cnt increments each clock and wraps from P-1 to 0.
- Each wrap increments bit_cnt.
- All bit decisions are taken on the edge where edge_cnt == P-1. This gives data_sampling's majority output (valid from edge_cnt == P/2+1) settle margin.

START:
- At edge_cnt == P-1: if sampled_bit == 1, treat as a glitch and go to IDLE with no outputs.
- Otherwise go to DATA with bit_cnt = 0.

DATA:
- At edge_cnt == P-1: P_DATA[bit_cnt] <= sampled_bit.
- After bit 7, go to PARITY if PAR_EN, else STOP.

PARITY:
- expected = ^P_DATA for even, ~^P_DATA for odd.
- At edge_cnt == P-1, latch perr = (sampled_bit != expected). Go to STOP.

STOP:
- At edge_cnt == P-1, compute serr = (sampled_bit == 0).
- On the same edge, register the frame result:
  - stp_err <= serr.
  - par_err <= perr & PAR_EN.
  - data_valid <= ~serr & ~(perr & PAR_EN).
- Next state is START if RX_IN == 0 (back-to-back frame; edge_cnt <= 0), else IDLE.

Latency and output rules:
- Output pulses appear after edge E0 + 10*P without parity, or E0 + 11*P with parity. Each pulse lasts exactly one cycle.
- data_valid is never asserted together with either error.
- P_DATA holds its value until overwritten bit-by-bit in the next frame's DATA state. Downstream captures P_DATA on the data_valid cycle.
- perr clears on entry to START.

Boundary and robustness:
- pre_scale outside {8, 16, 32} is undefined.
- A change of pre_scale mid-frame is undefined.
- Asynchronous reset mid-frame returns to IDLE immediately, forces all outputs to 0, and emits no pulse.
- bit_cnt is 4 bits; it never exceeds DATA_W-1 in DATA.

Decomposition:
- Shared package uart_rx_pkg:
  - state enum IDLE / START / DATA / PARITY / STOP.
  - localparams for legal prescale values 8, 16, 32.
  - DATA_W.
- Sub-module uart_rx_edge_bit_counter:
  - Inputs: enable, pre_scale, clear.
  - Outputs: edge_cnt, bit_cnt, last_edge = (edge_cnt == P-1).
- The FSM, shift register and parity/stop checks stay in uart_rx_ctrl.

Test Plan:
- Basic frame: P=8, PAR_EN=0, frame 0xA5 (start, 10100101 LSB-first, stop=1), with data_sampling instantiated. Expect P_DATA=0xA5 and a single data_valid pulse exactly 80 cycles after E0; no error pulses.
- Parity pass and fail: P=16, PAR_EN=1, PAR_TYP=0, byte 0x3C.
  - Parity bit 0: data_valid after 176 cycles.
  - Parity bit 1: par_err pulse only, no data_valid.
  - With PAR_TYP=1, the same two bits give the opposite results.
- Stop error: P=8, byte 0x00, stop bit driven 0. Expect stp_err pulse, data_valid = 0, and the FSM re-enters START because RX_IN is still low.
- Glitch start: RX_IN low for 2 cycles, then high, at P=8. Expect return to IDLE at edge_cnt 7, data_samp_en back to 0, no output pulses.
- Back-to-back frames: P=32, two frames 0x55 then 0xAA with no idle gap. Expect two data_valid pulses exactly 320 cycles apart, carrying correct data.
- Mid-frame reset: assert rst_n low during DATA bit 3. Expect all outputs 0 immediately. After release, a fresh 0x81 frame is received correctly.
